// File: rtl/s3g_host_master_pkg.sv
// S3G protocol constants, status codes and controller state encoding,
// shared by the host master and the slave-side framing blocks.
`default_nettype none

package s3g_host_master_pkg;

    localparam logic [7:0] S3G_SYNC  = 8'hD5;
    localparam logic [7:0] CRC8_POLY = 8'h8C;

    typedef enum logic [2:0] {
        ST_OK         = 3'd0,
        ST_ERR_LEN    = 3'd1,
        ST_TIMEOUT    = 3'd2,
        ST_BAD_LEN_RX = 3'd3,
        ST_BAD_CRC    = 3'd4,
        ST_OVERFLOW   = 3'd5
    } s3g_status_e;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_TX_HDR   = 4'd1,
        S_TX_LEN   = 4'd2,
        S_TX_FETCH = 4'd3,
        S_TX_PAY   = 4'd4,
        S_TX_CRC   = 4'd5,
        S_RX_HDR   = 4'd6,
        S_RX_LEN   = 4'd7,
        S_RX_PAY   = 4'd8,
        S_RX_CRC   = 4'd9,
        S_FINISH   = 4'd10
    } s3g_state_e;

endpackage

`default_nettype wire

// File: rtl/s3g_crc8_step.sv
// One-byte update of the reflected CRC-8 (Maxim/iButton) used for S3G payloads.
`default_nettype none

module s3g_crc8_step
    import s3g_host_master_pkg::*;
(
    input  logic [7:0] crc_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    always_comb begin
        logic [7:0] c;
        c = crc_i ^ data_i;
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC8_POLY) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

`default_nettype wire

// File: rtl/s3g_host_master.sv
// S3G host initiator: frames D5/len/payload/CRC8 to a UART, then captures
// and validates the response packet into a small readable buffer.
`default_nettype none

module s3g_host_master
    import s3g_host_master_pkg::*;
#(
    parameter int RSP_DEPTH   = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_start,
    input  logic [7:0] cmd_len,
    output logic       cmd_req,
    input  logic [7:0] cmd_data,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_done,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       busy,
    output logic       done,
    output logic [2:0] status,
    output logic [7:0] rsp_len,
    input  logic [7:0] rsp_addr,
    output logic [7:0] rsp_rdata
);

    localparam int            AW       = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [8:0]    DEPTH    = 9'(RSP_DEPTH);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    // Loaded one short so that done lands exactly TIMEOUT_CYC cycles after the last byte.
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

    s3g_state_e    state_q, state_d;
    s3g_status_e   status_q, status_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    crc_q, crc_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_wr_q, tx_wr_d;
    logic          req_q, req_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rsp_len_q, rsp_len_d;
    logic [7:0]    rsp_rdata_q;
    logic          buf_we;
    logic          rx_phase;
    logic [7:0]    crc_data;
    logic [7:0]    crc_next;
    logic [7:0]    mem [0:(1<<AW)-1];

    assign rx_phase = (state_q == S_RX_HDR) || (state_q == S_RX_LEN) ||
                      (state_q == S_RX_PAY) || (state_q == S_RX_CRC);
    assign crc_data = rx_phase ? rx_data : cmd_data;

    s3g_crc8_step u_crc (
        .crc_i  (crc_q),
        .data_i (crc_data),
        .crc_o  (crc_next)
    );

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        req_d     = req_q;
        tmo_d     = tmo_q;
        rsp_len_d = rsp_len_q;
        cmd_req   = 1'b0;
        buf_we    = 1'b0;

        // A byte arriving on the expiry cycle still counts and reloads the timer.
        if (rx_phase) begin
            if (rx_done) begin
                tmo_d = TMO_LOAD;
            end else if (tmo_q <= TMO_ONE) begin
                state_d  = S_FINISH;
                status_d = ST_TIMEOUT;
            end else begin
                tmo_d = tmo_q - TMO_ONE;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    if (cmd_len == 8'd0) begin
                        state_d  = S_FINISH;
                        status_d = ST_ERR_LEN;
                    end else begin
                        len_d     = cmd_len;
                        cnt_d     = 8'd0;
                        crc_d     = 8'd0;
                        tx_data_d = S3G_SYNC;
                        tx_wr_d   = 1'b1;
                        state_d   = S_TX_HDR;
                    end
                end
            end
            S_TX_HDR: begin
                if (tx_done) begin
                    tx_data_d = len_q;
                    tx_wr_d   = 1'b1;
                    state_d   = S_TX_LEN;
                end
            end
            S_TX_LEN: begin
                if (tx_done) begin
                    req_d   = 1'b0;
                    state_d = S_TX_FETCH;
                end
            end
            S_TX_FETCH: begin
                if (!req_q) begin
                    cmd_req = 1'b1;
                    req_d   = 1'b1;
                end else begin
                    tx_data_d = cmd_data;
                    tx_wr_d   = 1'b1;
                    crc_d     = crc_next;
                    cnt_d     = cnt_q + 8'd1;
                    req_d     = 1'b0;
                    state_d   = S_TX_PAY;
                end
            end
            S_TX_PAY: begin
                if (tx_done) begin
                    if (cnt_q == len_q) begin
                        tx_data_d = crc_q;
                        tx_wr_d   = 1'b1;
                        state_d   = S_TX_CRC;
                    end else begin
                        state_d = S_TX_FETCH;
                    end
                end
            end
            S_TX_CRC: begin
                if (tx_done) begin
                    tmo_d   = TMO_LOAD;
                    state_d = S_RX_HDR;
                end
            end
            S_RX_HDR: begin
                if (rx_done && (rx_data == S3G_SYNC)) begin
                    state_d = S_RX_LEN;
                end
            end
            S_RX_LEN: begin
                if (rx_done) begin
                    if (rx_data == 8'd0) begin
                        state_d  = S_FINISH;
                        status_d = ST_BAD_LEN_RX;
                    end else begin
                        rsp_len_d = rx_data;
                        crc_d     = 8'd0;
                        cnt_d     = 8'd0;
                        state_d   = S_RX_PAY;
                    end
                end
            end
            S_RX_PAY: begin
                if (rx_done) begin
                    buf_we = ({1'b0, cnt_q} < DEPTH);
                    crc_d  = crc_next;
                    cnt_d  = cnt_q + 8'd1;
                    if ((cnt_q + 8'd1) == rsp_len_q) begin
                        state_d = S_RX_CRC;
                    end
                end
            end
            S_RX_CRC: begin
                if (rx_done) begin
                    state_d = S_FINISH;
                    if (rx_data != crc_q) begin
                        status_d = ST_BAD_CRC;
                    end else if ({1'b0, rsp_len_q} > DEPTH) begin
                        status_d = ST_OVERFLOW;
                    end else begin
                        status_d = ST_OK;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            status_q  <= ST_OK;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            crc_q     <= 8'd0;
            tx_data_q <= 8'd0;
            tx_wr_q   <= 1'b0;
            req_q     <= 1'b0;
            tmo_q     <= '0;
            rsp_len_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            req_q     <= req_d;
            tmo_q     <= tmo_d;
            rsp_len_q <= rsp_len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            mem[cnt_q[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata_q <= 8'd0;
        end else begin
            rsp_rdata_q <= ({1'b0, rsp_addr} < DEPTH) ? mem[rsp_addr[AW-1:0]] : 8'd0;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_wr     = tx_wr_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done      = (state_q == S_FINISH);
    assign status    = status_q;
    assign rsp_len   = rsp_len_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_s3g_host_master.sv
// Directed bench for s3g_host_master: a 16-deep and a 4-deep instance share all stimulus.
`default_nettype none

module tb_s3g_host_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cmd_start, tx_done, rx_done;
    logic [7:0] cmd_len, cmd_data, rx_data, rsp_addr;

    logic       cmd_req_a, tx_wr_a, busy_a, done_a;
    logic [7:0] tx_data_a, rsp_len_a, rsp_rdata_a;
    logic [2:0] status_a;
    logic       cmd_req_b, tx_wr_b, busy_b, done_b;
    logic [7:0] tx_data_b, rsp_len_b, rsp_rdata_b;
    logic [2:0] status_b;

    s3g_host_master #(.RSP_DEPTH(16), .TIMEOUT_CYC(100)) dut_a (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_len(cmd_len),
        .cmd_req(cmd_req_a), .cmd_data(cmd_data), .tx_data(tx_data_a), .tx_wr(tx_wr_a),
        .tx_done(tx_done), .rx_data(rx_data), .rx_done(rx_done), .busy(busy_a),
        .done(done_a), .status(status_a), .rsp_len(rsp_len_a), .rsp_addr(rsp_addr),
        .rsp_rdata(rsp_rdata_a)
    );

    s3g_host_master #(.RSP_DEPTH(4), .TIMEOUT_CYC(100)) dut_b (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_len(cmd_len),
        .cmd_req(cmd_req_b), .cmd_data(cmd_data), .tx_data(tx_data_b), .tx_wr(tx_wr_b),
        .tx_done(tx_done), .rx_data(rx_data), .rx_done(rx_done), .busy(busy_b),
        .done(done_b), .status(status_b), .rsp_len(rsp_len_b), .rsp_addr(rsp_addr),
        .rsp_rdata(rsp_rdata_b)
    );

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  req_cnt, pay_idx, wr_viol, done_cnt, tx_dly, last_rx_cyc;
    bit  tx_pend, tx_en;
    logic [7:0] tx_log[$];

    logic [7:0] exp_tx [10] = '{8'hD5, 8'h07, 8'h76, 8'h54, 8'h81, 8'hDE, 8'h03, 8'h00, 8'h00, 8'h59};
    logic [7:0] rsp_in [10] = '{8'hFF, 8'hD5, 8'h07, 8'h76, 8'h54, 8'h81, 8'hDE, 8'h03, 8'h00, 8'h00};

    // One clock step; also plays the UART TX side and the payload source.
    task automatic step();
        @(negedge clk);
        cyc++;
        tx_done = 1'b0;
        if (tx_wr_a) begin
            if (tx_pend) wr_viol++;
            tx_log.push_back(tx_data_a);
            tx_pend = 1'b1;
            tx_dly  = 2;
        end else if (tx_pend && tx_en) begin
            if (tx_dly == 0) begin
                tx_done = 1'b1;
                tx_pend = 1'b0;
            end else begin
                tx_dly--;
            end
        end
        if (cmd_req_a) begin
            req_cnt++;
            cmd_data = (pay_idx < 7) ? exp_tx[pay_idx + 2] : 8'hEE;
            pay_idx++;
        end
        if (done_a) done_cnt++;
    endtask

    task automatic run_tx(input bit poke);
        bit ok;
        tx_log.delete();
        req_cnt = 0; pay_idx = 0; wr_viol = 0; tx_pend = 1'b0; done_cnt = 0;
        cmd_len = 8'd7; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (poke && i == 15) begin
                cmd_start = 1'b1; cmd_len = 8'd0;
            end else begin
                cmd_start = 1'b0; cmd_len = 8'd7;
            end
            step();
            if (tx_log.size() == 10 && !tx_pend) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_start = 1'b0;
        step();
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL tx_complete: got %0d tx bytes, required 10", tx_log.size());
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, input bit gap);
        rx_data = b; rx_done = 1'b1; last_rx_cyc = cyc;
        step();
        rx_done = 1'b0;
        if (gap) step();
    endtask

    task automatic feed_rsp(input logic [7:0] last);
        for (int i = 0; i < 10; i++) rx_byte(rsp_in[i], 1'b1);
        rx_byte(last, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_start = 1'b0; cmd_len = 8'd0; cmd_data = 8'd0; tx_done = 1'b0;
        rx_done = 1'b0; rx_data = 8'd0; rsp_addr = 8'd0; tx_en = 1'b1; tx_pend = 1'b0;
        repeat (3) step();
        tests++; if (busy_a !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b, required 0", busy_a); end
        tests++; if (done_a !== 1'b0)     begin fails++; $display("FAIL reset_done: got %b, required 0", done_a); end
        tests++; if (tx_wr_a !== 1'b0)    begin fails++; $display("FAIL reset_tx_wr: got %b, required 0", tx_wr_a); end
        tests++; if (cmd_req_a !== 1'b0)  begin fails++; $display("FAIL reset_cmd_req: got %b, required 0", cmd_req_a); end
        tests++; if (tx_data_a !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h, required 00", tx_data_a); end
        tests++; if (status_a !== 3'd0)   begin fails++; $display("FAIL reset_status: got %0d, required 0", status_a); end
        tests++; if (rsp_len_a !== 8'd0)  begin fails++; $display("FAIL reset_rsp_len: got %0d, required 0", rsp_len_a); end
        tests++; if (rsp_rdata_a !== 8'd0) begin fails++; $display("FAIL reset_rsp_rdata: got %h, required 00", rsp_rdata_a); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_tx();
        run_tx(1'b1);
        tests++; if (tx_log.size() != 10) begin fails++; $display("FAIL tx_count: got %0d, required 10", tx_log.size()); end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (i >= tx_log.size()) begin
                fails++; $display("FAIL tx_byte[%0d]: missing, required %h", i, exp_tx[i]);
            end else if (tx_log[i] !== exp_tx[i]) begin
                fails++; $display("FAIL tx_byte[%0d]: got %h, required %h", i, tx_log[i], exp_tx[i]);
            end
        end
        tests++; if (wr_viol != 0)  begin fails++; $display("FAIL tx_handshake: got %0d early writes, required 0", wr_viol); end
        tests++; if (req_cnt != 7)  begin fails++; $display("FAIL cmd_req_count: got %0d, required 7", req_cnt); end
        tests++; if (done_cnt != 0) begin fails++; $display("FAIL busy_start_ignored: got %0d done pulses, required 0", done_cnt); end
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL tx_busy: got %b, required 1", busy_a); end
    endtask

    task automatic test_rx_ok();
        feed_rsp(8'h59);
        tests++; if (done_a !== 1'b1)   begin fails++; $display("FAIL rx_ok_done: got %b, required 1", done_a); end
        tests++; if (status_a !== 3'd0) begin fails++; $display("FAIL rx_ok_status: got %0d, required 0", status_a); end
        tests++; if (rsp_len_a !== 8'd7) begin fails++; $display("FAIL rx_ok_len: got %0d, required 7", rsp_len_a); end
        step();
        tests++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            fails++; $display("FAIL rx_ok_after: got done=%b busy=%b, required 0 0", done_a, busy_a);
        end
        for (int i = 0; i < 7; i++) begin
            rsp_addr = 8'(i);
            step();
            tests++;
            if (rsp_rdata_a !== exp_tx[i + 2]) begin
                fails++; $display("FAIL rx_ok_buf[%0d]: got %h, required %h", i, rsp_rdata_a, exp_tx[i + 2]);
            end
        end
    endtask

    task automatic test_bad_crc();
        run_tx(1'b0);
        feed_rsp(8'h58);
        tests++; if (done_a !== 1'b1 || status_a !== 3'd4) begin
            fails++; $display("FAIL bad_crc: got done=%b status=%0d, required 1 4", done_a, status_a);
        end
        step();
    endtask

    task automatic test_overflow();
        run_tx(1'b0);
        for (int i = 0; i < 10; i++) rx_byte(rsp_in[i], 1'b1);
        tests++; if (done_b !== 1'b0 || busy_b !== 1'b1) begin
            fails++; $display("FAIL ovf_before_crc: got done=%b busy=%b, required 0 1", done_b, busy_b);
        end
        rx_byte(8'h59, 1'b0);
        tests++; if (done_b !== 1'b1 || status_b !== 3'd5) begin
            fails++; $display("FAIL ovf_status: got done=%b status=%0d, required 1 5", done_b, status_b);
        end
        tests++; if (rsp_len_b !== 8'd7) begin fails++; $display("FAIL ovf_len: got %0d, required 7", rsp_len_b); end
        step();
        for (int i = 0; i < 4; i++) begin
            rsp_addr = 8'(i);
            step();
            tests++;
            if (rsp_rdata_b !== exp_tx[i + 2]) begin
                fails++; $display("FAIL ovf_buf[%0d]: got %h, required %h", i, rsp_rdata_b, exp_tx[i + 2]);
            end
        end
    endtask

    task automatic test_timeout();
        bit seen;
        run_tx(1'b0);
        rx_byte(8'hD5, 1'b1);
        rx_byte(8'h03, 1'b1);
        rx_byte(8'h76, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_a) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        tests++; if (!seen || (cyc - last_rx_cyc) != 100) begin
            fails++; $display("FAIL timeout_delay: got %0d cycles (seen=%b), required 100", cyc - last_rx_cyc, seen);
        end
        tests++; if (status_a !== 3'd2) begin fails++; $display("FAIL timeout_status: got %0d, required 2", status_a); end
        step();
    endtask

    task automatic test_err_len();
        tx_log.delete(); tx_pend = 1'b0;
        cmd_len = 8'd0; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        tests++; if (done_a !== 1'b1 || status_a !== 3'd1) begin
            fails++; $display("FAIL err_len: got done=%b status=%0d, required 1 1", done_a, status_a);
        end
        repeat (5) step();
        tests++; if (tx_log.size() != 0 || busy_a !== 1'b0) begin
            fails++; $display("FAIL err_len_quiet: got %0d tx writes busy=%b, required 0 0", tx_log.size(), busy_a);
        end
    endtask

    task automatic test_reset_mid();
        tx_log.delete(); tx_pend = 1'b0;
        cmd_len = 8'd7; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (tx_log.size() == 3) break;
        end
        tx_en = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++; if (busy_a !== 1'b0 || tx_wr_a !== 1'b0 || cmd_req_a !== 1'b0) begin
            fails++; $display("FAIL reset_mid: got busy=%b tx_wr=%b cmd_req=%b, required 0 0 0", busy_a, tx_wr_a, cmd_req_a);
        end
        tx_pend = 1'b0; tx_en = 1'b1;
        tx_done = 1'b1;
        step();
        repeat (5) step();
        tests++; if (tx_log.size() != 3 || busy_a !== 1'b0) begin
            fails++; $display("FAIL late_tx_done: got %0d tx bytes busy=%b, required 3 0", tx_log.size(), busy_a);
        end
    endtask

    task automatic test_back_to_back();
        run_tx(1'b0);
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (i >= tx_log.size() || tx_log[i] !== exp_tx[i]) begin
                fails++; $display("FAIL b2b_tx[%0d]: got %h, required %h", i,
                                  (i < tx_log.size()) ? tx_log[i] : 8'hXX, exp_tx[i]);
            end
        end
        feed_rsp(8'h59);
        tests++; if (done_a !== 1'b1 || status_a !== 3'd0) begin
            fails++; $display("FAIL b2b_rx: got done=%b status=%0d, required 1 0", done_a, status_a);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx_ok();
        test_bad_crc();
        test_overflow();
        test_timeout();
        test_err_len();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1);
    end

endmodule

`default_nettype wire
